// File: rtl/burst_pkg.sv
// Shared constants for the on-off keyed pulse-burst link.
// The generator and the receive-side detector take their timing from here,
// so both ends of the link agree on one set of numbers.
package burst_pkg;

   // Nominal burst timing, in clk cycles.
   localparam int unsigned HIGH_CYC     = 330;   // pulse high time
   localparam int unsigned PERIOD_CYC   = 1316;  // rise-to-rise period
   localparam int unsigned TOL          = 16;    // +/- on high time and period
   localparam int unsigned BURST_PULSES = 21;    // pulses per burst
   localparam int unsigned GAP_PERIODS  = 63;    // silent periods after a burst
   localparam int unsigned GAP_TOL      = 64;    // +/- on the gap measurement
   // Must hold (GAP_PERIODS+1)*PERIOD_CYC+GAP_TOL = 84288.
   localparam int unsigned CNT_W        = 18;

   // Detector state encoding.
   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_BURST = 2'd1;
   localparam logic [1:0] ST_GAP   = 2'd2;

   // Error cause reported alongside frame_err.
   localparam logic [1:0] ERR_HIGH   = 2'd0;
   localparam logic [1:0] ERR_PERIOD = 2'd1;
   localparam logic [1:0] ERR_COUNT  = 2'd2;
   localparam logic [1:0] ERR_GAP    = 2'd3;

   // Inclusive tolerance window |x - nom| <= tol, written without subtraction
   // so unsigned operands can never underflow.
   function automatic logic in_window(input logic [31:0] x,
                                      input logic [31:0] nom,
                                      input logic [31:0] tol);
      return ((x + tol) >= nom) && (x <= (nom + tol));
   endfunction

endpackage

// File: rtl/sync_edge_det.sv
// Pad-input front end: two-flop synchronizer, a registered previous sample,
// and registered one-cycle rise/fall strobes. Strobes appear a fixed three
// clocks after the pad edge; downstream timing is measured strobe-to-strobe,
// so this latency cancels out.
module sync_edge_det (
   input  logic clk,
   input  logic rst,
   input  logic async_i,
   output logic rise_o,
   output logic fall_o
);

   logic sync1_q;
   logic sync2_q;
   logic prev_q;
   logic rise_q;
   logic fall_q;

   // Synchronize the asynchronous line and register edge strobes.
   always_ff @(posedge clk) begin
      if (rst) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         prev_q  <= 1'b0;
         rise_q  <= 1'b0;
         fall_q  <= 1'b0;
      end else begin
         sync1_q <= async_i;
         sync2_q <= sync1_q;
         prev_q  <= sync2_q;
         rise_q  <= sync2_q & ~prev_q;
         fall_q  <= ~sync2_q & prev_q;
      end
   end

   assign rise_o = rise_q;
   assign fall_o = fall_q;

endmodule

// File: rtl/burst_rx_detector.sv
// Receive-side checker for the pulse-burst pattern. Measures every pulse
// high time, every rise-to-rise period and the inter-burst gap in clk
// cycles, counts pulses per burst and reports one registered frame_ok or
// frame_err pulse per decision. locked tells the link controller that at
// least one complete frame has been seen since the last violation.
module burst_rx_detector
   import burst_pkg::*;
#(
   parameter int unsigned HIGH_CYC     = burst_pkg::HIGH_CYC,
   parameter int unsigned PERIOD_CYC   = burst_pkg::PERIOD_CYC,
   parameter int unsigned TOL          = burst_pkg::TOL,
   parameter int unsigned BURST_PULSES = burst_pkg::BURST_PULSES,
   parameter int unsigned GAP_PERIODS  = burst_pkg::GAP_PERIODS,
   parameter int unsigned GAP_TOL      = burst_pkg::GAP_TOL,
   parameter int unsigned CNT_W        = burst_pkg::CNT_W
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       line_in,
   output logic       frame_ok,
   output logic       frame_err,
   output logic [1:0] err_code,
   output logic       locked,
   output logic [4:0] pulse_count
);

   // Silence longer than this after a rise means the burst has ended.
   localparam logic [31:0] BURST_END = 32'(PERIOD_CYC + TOL + 1);
   // Gap is measured from the last burst rise to the next frame's first rise.
   localparam logic [31:0] GAP_NOM   = 32'((GAP_PERIODS + 1) * PERIOD_CYC);
   localparam logic [31:0] GAP_MAX   = 32'((GAP_PERIODS + 1) * PERIOD_CYC + GAP_TOL);
   localparam logic [4:0]  PC_MAX    = 5'd31;

   logic             rise_s;
   logic             fall_s;

   logic [1:0]       state_q,       state_d;
   logic [CNT_W-1:0] elapsed_q,     elapsed_d;
   logic [CNT_W-1:0] high_len_q,    high_len_d;
   logic [4:0]       pulse_count_q, pulse_count_d;
   logic             frame_ok_q,    frame_ok_d;
   logic             frame_err_q,   frame_err_d;
   logic [1:0]       err_code_q,    err_code_d;
   logic             locked_q,      locked_d;

   logic [31:0]      elapsed_ext_s;
   logic             high_ok_s;
   logic             period_ok_s;
   logic             gap_ok_s;
   logic             burst_full_s;
   logic             err_hit_s;
   logic [1:0]       err_sel_s;

   sync_edge_det u_sync (
      .clk     (clk),
      .rst     (rst),
      .async_i (line_in),
      .rise_o  (rise_s),
      .fall_o  (fall_s)
   );

   // Window checks on the current elapsed count, taken before any clear.
   always_comb begin
      elapsed_ext_s = 32'(elapsed_q);
      high_ok_s     = in_window(elapsed_ext_s, 32'(HIGH_CYC), 32'(TOL));
      period_ok_s   = in_window(elapsed_ext_s, 32'(PERIOD_CYC), 32'(TOL));
      gap_ok_s      = in_window(elapsed_ext_s, GAP_NOM, 32'(GAP_TOL));
      burst_full_s  = (32'(pulse_count_q) == 32'(BURST_PULSES));
   end

   // Counters, frame state machine and error arbitration.
   always_comb begin
      state_d       = state_q;
      high_len_d    = high_len_q;
      pulse_count_d = pulse_count_q;
      frame_ok_d    = 1'b0;
      frame_err_d   = 1'b0;
      err_code_d    = err_code_q;
      locked_d      = locked_q;
      err_hit_s     = 1'b0;
      err_sel_s     = ERR_HIGH;

      // elapsed restarts at 1 on every rise and saturates rather than wrapping.
      if (rise_s) begin
         elapsed_d = CNT_W'(1'b1);
      end else if (elapsed_q != {CNT_W{1'b1}}) begin
         elapsed_d = elapsed_q + CNT_W'(1'b1);
      end else begin
         elapsed_d = elapsed_q;
      end

      if (fall_s) begin
         high_len_d = elapsed_q;
      end else begin
         high_len_d = high_len_q;
      end

      case (state_q)
         ST_IDLE: begin
            if (rise_s) begin
               state_d       = ST_BURST;
               pulse_count_d = 5'd1;
            end else begin
               state_d = ST_IDLE;
            end
         end

         ST_BURST: begin
            if (rise_s) begin
               if (!period_ok_s) begin
                  err_hit_s = 1'b1;
                  err_sel_s = ERR_PERIOD;
               end else if (burst_full_s) begin
                  // One pulse too many: the period check could not end the burst.
                  err_hit_s = 1'b1;
                  err_sel_s = ERR_COUNT;
               end else if (pulse_count_q != PC_MAX) begin
                  pulse_count_d = pulse_count_q + 5'd1;
               end else begin
                  pulse_count_d = pulse_count_q;
               end
            end else if (fall_s) begin
               if (!high_ok_s) begin
                  err_hit_s = 1'b1;
                  err_sel_s = ERR_HIGH;
               end else begin
                  err_hit_s = 1'b0;
               end
            end else if (elapsed_ext_s == BURST_END) begin
               if (burst_full_s) begin
                  state_d = ST_GAP;
               end else begin
                  err_hit_s = 1'b1;
                  err_sel_s = ERR_COUNT;
               end
            end else begin
               state_d = ST_BURST;
            end
         end

         ST_GAP: begin
            if (rise_s) begin
               if (gap_ok_s) begin
                  // This rise is also the first pulse of the next frame.
                  frame_ok_d    = 1'b1;
                  locked_d      = 1'b1;
                  state_d       = ST_BURST;
                  pulse_count_d = 5'd1;
               end else begin
                  err_hit_s = 1'b1;
                  err_sel_s = ERR_GAP;
               end
            end else if (elapsed_ext_s > GAP_MAX) begin
               // Line has gone dead; the error path returns to IDLE.
               err_hit_s = 1'b1;
               err_sel_s = ERR_GAP;
            end else begin
               state_d = ST_GAP;
            end
         end

         default: begin
            state_d       = ST_IDLE;
            pulse_count_d = 5'd0;
         end
      endcase

      // A violation on a rise resynchronizes on that edge; otherwise wait in IDLE.
      if (err_hit_s) begin
         frame_ok_d  = 1'b0;
         frame_err_d = 1'b1;
         err_code_d  = err_sel_s;
         locked_d    = 1'b0;
         if (rise_s) begin
            state_d       = ST_BURST;
            pulse_count_d = 5'd1;
         end else begin
            state_d       = ST_IDLE;
            pulse_count_d = 5'd0;
         end
      end else begin
         frame_err_d = 1'b0;
      end
   end

   // State and registered outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= ST_IDLE;
         elapsed_q     <= {CNT_W{1'b0}};
         high_len_q    <= {CNT_W{1'b0}};
         pulse_count_q <= 5'd0;
         frame_ok_q    <= 1'b0;
         frame_err_q   <= 1'b0;
         err_code_q    <= 2'd0;
         locked_q      <= 1'b0;
      end else begin
         state_q       <= state_d;
         elapsed_q     <= elapsed_d;
         high_len_q    <= high_len_d;
         pulse_count_q <= pulse_count_d;
         frame_ok_q    <= frame_ok_d;
         frame_err_q   <= frame_err_d;
         err_code_q    <= err_code_d;
         locked_q      <= locked_d;
      end
   end

   assign frame_ok    = frame_ok_q;
   assign frame_err   = frame_err_q;
   assign err_code    = err_code_q;
   assign locked      = locked_q;
   assign pulse_count = pulse_count_q;

endmodule

// File: tb/tb_burst_rx_detector.sv
// Directed bench for burst_rx_detector with scaled-down timing so whole
// frames fit in a short run. Line edges are driven on the falling clock
// edge; a falling-edge monitor logs every frame_ok / frame_err pulse with
// its cycle number so the scenario tasks can check count, cause and timing.
module tb_burst_rx_detector;

   localparam int H    = 33;            // high time
   localparam int P    = 132;           // period
   localparam int T    = 4;             // tolerance
   localparam int BP   = 6;             // pulses per burst
   localparam int GP   = 5;             // gap periods
   localparam int GT   = 8;             // gap tolerance
   localparam int CW   = 10;            // counter width (holds 800)
   localparam int GAPN = (GP + 1) * P;  // 792, last burst rise to next rise
   localparam int GMAX = GAPN + GT;     // 800
   localparam int LAT  = 4;             // pad edge -> registered output, in clk

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       line_in = 1'b0;
   logic       frame_ok;
   logic       frame_err;
   logic [1:0] err_code;
   logic       locked;
   logic [4:0] pulse_count;

   int         cyc = 0;
   int         ok_cnt = 0;
   int         err_cnt = 0;
   int         both_cnt = 0;
   int         ok_cyc = 0;
   int         err_cyc = 0;
   logic [1:0] last_code = 2'd0;

   int         n_checks = 0;
   int         n_pass = 0;
   int         rise_cyc = 0;
   int         fall_cyc = 0;

   burst_rx_detector #(
      .HIGH_CYC(H), .PERIOD_CYC(P), .TOL(T), .BURST_PULSES(BP),
      .GAP_PERIODS(GP), .GAP_TOL(GT), .CNT_W(CW)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .line_in     (line_in),
      .frame_ok    (frame_ok),
      .frame_err   (frame_err),
      .err_code    (err_code),
      .locked      (locked),
      .pulse_count (pulse_count)
   );

   always #5 clk = ~clk;

   // Cycle counter, advanced on the active edge.
   always @(posedge clk) cyc <= cyc + 1;

   // Event monitor, sampling away from the active edge.
   always @(negedge clk) begin
      if (frame_ok) begin
         ok_cnt <= ok_cnt + 1;
         ok_cyc <= cyc;
      end
      if (frame_err) begin
         err_cnt   <= err_cnt + 1;
         err_cyc   <= cyc;
         last_code <= err_code;
      end
      if (frame_ok && frame_err) both_cnt <= both_cnt + 1;
   end

   task automatic wait_cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   // One pulse: rise now, fall after hi cycles, return per cycles after the rise.
   task automatic pulse(input int hi, input int per);
      line_in  = 1'b1;
      rise_cyc = cyc;
      wait_cyc(hi);
      line_in  = 1'b0;
      fall_cyc = cyc;
      wait_cyc(per - hi);
   endtask

   task automatic test_reset;
      wait_cyc(3);
      n_checks++; if (frame_ok !== 1'b0) $display("FAIL rst_ok: got %0b want 0", frame_ok); else n_pass++;
      n_checks++; if (frame_err !== 1'b0) $display("FAIL rst_err: got %0b want 0", frame_err); else n_pass++;
      n_checks++; if (err_code !== 2'd0) $display("FAIL rst_code: got %0d want 0", err_code); else n_pass++;
      n_checks++; if (locked !== 1'b0) $display("FAIL rst_locked: got %0b want 0", locked); else n_pass++;
      n_checks++; if (pulse_count !== 5'd0) $display("FAIL rst_pc: got %0d want 0", pulse_count); else n_pass++;
      rst = 1'b0;
      wait_cyc(5);
   endtask

   task automatic test_nominal;
      int ok0, err0;
      ok0 = ok_cnt; err0 = err_cnt;
      repeat (BP) pulse(H, P);
      n_checks++; if (pulse_count !== 5'(BP)) $display("FAIL nom_pc_burst: got %0d want %0d", pulse_count, BP); else n_pass++;
      n_checks++; if (locked !== 1'b0) $display("FAIL nom_unlocked: got %0b want 0", locked); else n_pass++;
      wait_cyc(GAPN - P);
      pulse(H, P);
      n_checks++; if (ok_cnt - ok0 !== 1) $display("FAIL nom_ok_cnt: got %0d want 1", ok_cnt - ok0); else n_pass++;
      n_checks++; if (ok_cyc !== rise_cyc + LAT) $display("FAIL nom_ok_time: got %0d want %0d", ok_cyc, rise_cyc + LAT); else n_pass++;
      n_checks++; if (locked !== 1'b1) $display("FAIL nom_locked: got %0b want 1", locked); else n_pass++;
      n_checks++; if (pulse_count !== 5'd1) $display("FAIL nom_pc_new: got %0d want 1", pulse_count); else n_pass++;
      repeat (BP - 1) pulse(H, P);
      wait_cyc(GAPN - P);
      pulse(H, P);
      n_checks++; if (ok_cnt - ok0 !== 2) $display("FAIL nom_ok_cnt2: got %0d want 2", ok_cnt - ok0); else n_pass++;
      n_checks++; if (err_cnt - err0 !== 0) $display("FAIL nom_no_err: got %0d want 0", err_cnt - err0); else n_pass++;
   endtask

   task automatic test_high_err;
      int ok0, err0;
      err0 = err_cnt;
      repeat (3) pulse(H, P);
      pulse(H + T + 1, P);
      n_checks++; if (err_cnt - err0 !== 1) $display("FAIL hi_err_cnt: got %0d want 1", err_cnt - err0); else n_pass++;
      n_checks++; if (last_code !== 2'd0) $display("FAIL hi_code: got %0d want 0", last_code); else n_pass++;
      n_checks++; if (err_cyc !== fall_cyc + LAT) $display("FAIL hi_time: got %0d want %0d", err_cyc, fall_cyc + LAT); else n_pass++;
      n_checks++; if (locked !== 1'b0) $display("FAIL hi_locked: got %0b want 0", locked); else n_pass++;
      n_checks++; if (pulse_count !== 5'd0) $display("FAIL hi_pc: got %0d want 0", pulse_count); else n_pass++;
      wait_cyc(3 * P);
      // Frame with every measurement at the edge of its window.
      ok0 = ok_cnt; err0 = err_cnt;
      pulse(H, P);
      pulse(H + T, P);
      pulse(H - T, P + T);
      pulse(H, P - T);
      pulse(H, P);
      pulse(H, P);
      wait_cyc(GMAX - P);
      pulse(H, P);
      n_checks++; if (ok_cnt - ok0 !== 1) $display("FAIL edge_ok_cnt: got %0d want 1", ok_cnt - ok0); else n_pass++;
      n_checks++; if (err_cnt - err0 !== 0) $display("FAIL edge_no_err: got %0d want 0", err_cnt - err0); else n_pass++;
      n_checks++; if (locked !== 1'b1) $display("FAIL edge_locked: got %0b want 1", locked); else n_pass++;
   endtask

   task automatic test_period_err;
      int ok0, err0;
      ok0 = ok_cnt; err0 = err_cnt;
      pulse(H, P);
      pulse(H, P + T + 1);
      pulse(H, P);
      n_checks++; if (err_cnt - err0 !== 1) $display("FAIL per_err_cnt: got %0d want 1", err_cnt - err0); else n_pass++;
      n_checks++; if (last_code !== 2'd1) $display("FAIL per_code: got %0d want 1", last_code); else n_pass++;
      n_checks++; if (err_cyc !== rise_cyc + LAT) $display("FAIL per_time: got %0d want %0d", err_cyc, rise_cyc + LAT); else n_pass++;
      n_checks++; if (pulse_count !== 5'd1) $display("FAIL per_pc: got %0d want 1", pulse_count); else n_pass++;
      n_checks++; if (locked !== 1'b0) $display("FAIL per_locked: got %0b want 0", locked); else n_pass++;
      repeat (BP - 1) pulse(H, P);
      wait_cyc(GAPN - P);
      pulse(H, P);
      n_checks++; if (ok_cnt - ok0 !== 1) $display("FAIL per_resync_ok: got %0d want 1", ok_cnt - ok0); else n_pass++;
      n_checks++; if (err_cnt - err0 !== 1) $display("FAIL per_resync_err: got %0d want 1", err_cnt - err0); else n_pass++;
   endtask

   task automatic test_count_short;
      int err0, last;
      err0 = err_cnt;
      repeat (BP - 2) pulse(H, P);
      last = rise_cyc;
      wait_cyc(20);
      n_checks++; if (err_cnt - err0 !== 1) $display("FAIL short_err_cnt: got %0d want 1", err_cnt - err0); else n_pass++;
      n_checks++; if (last_code !== 2'd2) $display("FAIL short_code: got %0d want 2", last_code); else n_pass++;
      n_checks++; if (err_cyc !== last + LAT + P + T + 1) $display("FAIL short_time: got %0d want %0d", err_cyc, last + LAT + P + T + 1); else n_pass++;
      n_checks++; if (pulse_count !== 5'd0) $display("FAIL short_pc: got %0d want 0", pulse_count); else n_pass++;
      n_checks++; if (locked !== 1'b0) $display("FAIL short_locked: got %0b want 0", locked); else n_pass++;
   endtask

   task automatic test_count_long;
      int err0;
      err0 = err_cnt;
      repeat (BP + 1) pulse(H, P);
      n_checks++; if (err_cnt - err0 !== 1) $display("FAIL long_err_cnt: got %0d want 1", err_cnt - err0); else n_pass++;
      n_checks++; if (last_code !== 2'd2) $display("FAIL long_code: got %0d want 2", last_code); else n_pass++;
      n_checks++; if (err_cyc !== rise_cyc + LAT) $display("FAIL long_time: got %0d want %0d", err_cyc, rise_cyc + LAT); else n_pass++;
      n_checks++; if (pulse_count !== 5'd1) $display("FAIL long_pc: got %0d want 1", pulse_count); else n_pass++;
      wait_cyc(20);
      n_checks++; if (err_cnt - err0 !== 2) $display("FAIL long_tail_err: got %0d want 2", err_cnt - err0); else n_pass++;
      n_checks++; if (pulse_count !== 5'd0) $display("FAIL long_tail_pc: got %0d want 0", pulse_count); else n_pass++;
   endtask

   task automatic test_gap;
      int err0, last;
      err0 = err_cnt;
      repeat (BP) pulse(H, P);
      wait_cyc(GAPN - GT - 1 - P);
      pulse(H, P);
      n_checks++; if (err_cnt - err0 !== 1) $display("FAIL gap_early_cnt: got %0d want 1", err_cnt - err0); else n_pass++;
      n_checks++; if (last_code !== 2'd3) $display("FAIL gap_early_code: got %0d want 3", last_code); else n_pass++;
      n_checks++; if (err_cyc !== rise_cyc + LAT) $display("FAIL gap_early_time: got %0d want %0d", err_cyc, rise_cyc + LAT); else n_pass++;
      n_checks++; if (pulse_count !== 5'd1) $display("FAIL gap_early_pc: got %0d want 1", pulse_count); else n_pass++;
      repeat (BP - 1) pulse(H, P);
      last = rise_cyc;
      wait_cyc(GMAX + 1 - P + 20);
      n_checks++; if (err_cnt - err0 !== 2) $display("FAIL gap_dead_cnt: got %0d want 2", err_cnt - err0); else n_pass++;
      n_checks++; if (last_code !== 2'd3) $display("FAIL gap_dead_code: got %0d want 3", last_code); else n_pass++;
      n_checks++; if (err_cyc !== last + LAT + GMAX + 1) $display("FAIL gap_dead_time: got %0d want %0d", err_cyc, last + LAT + GMAX + 1); else n_pass++;
      n_checks++; if (pulse_count !== 5'd0) $display("FAIL gap_dead_pc: got %0d want 0", pulse_count); else n_pass++;
   endtask

   task automatic test_reset_mid;
      int ok0, err0;
      ok0 = ok_cnt; err0 = err_cnt;
      repeat (BP) pulse(H, P);
      wait_cyc(GAPN - P);
      pulse(H, P);
      n_checks++; if (locked !== 1'b1) $display("FAIL mid_pre_locked: got %0b want 1", locked); else n_pass++;
      pulse(H, P);
      pulse(H, P);
      rst = 1'b1;
      wait_cyc(1);
      rst = 1'b0;
      n_checks++; if (frame_ok !== 1'b0) $display("FAIL mid_ok: got %0b want 0", frame_ok); else n_pass++;
      n_checks++; if (frame_err !== 1'b0) $display("FAIL mid_err: got %0b want 0", frame_err); else n_pass++;
      n_checks++; if (err_code !== 2'd0) $display("FAIL mid_code: got %0d want 0", err_code); else n_pass++;
      n_checks++; if (locked !== 1'b0) $display("FAIL mid_locked: got %0b want 0", locked); else n_pass++;
      n_checks++; if (pulse_count !== 5'd0) $display("FAIL mid_pc: got %0d want 0", pulse_count); else n_pass++;
      wait_cyc(P);
      repeat (BP) pulse(H, P);
      wait_cyc(GAPN - P);
      pulse(H, P);
      n_checks++; if (ok_cnt - ok0 !== 2) $display("FAIL mid_post_ok: got %0d want 2", ok_cnt - ok0); else n_pass++;
      n_checks++; if (err_cnt - err0 !== 0) $display("FAIL mid_post_err: got %0d want 0", err_cnt - err0); else n_pass++;
      n_checks++; if (locked !== 1'b1) $display("FAIL mid_post_locked: got %0b want 1", locked); else n_pass++;
   endtask

   initial begin
      @(negedge clk);
      test_reset();
      test_nominal();
      test_high_err();
      test_period_err();
      test_count_short();
      test_count_long();
      test_gap();
      test_reset_mid();
      wait_cyc(5);
      n_checks++; if (both_cnt !== 0) $display("FAIL ok_err_overlap: got %0d want 0", both_cnt); else n_pass++;
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
